// File: rtl/proc_ctrl_pkg.sv
// Shared types for the processor sequencer: opcodes, ALU ops, FSM states, control bus.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package proc_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_ADDI = 4'd7,
        OP_LD   = 4'd8,
        OP_ST   = 4'd9,
        OP_BZ   = 4'd10,
        OP_BNZ  = 4'd11,
        OP_JMP  = 4'd12,
        OP_JMPR = 4'd13,
        OP_LDPC = 4'd14,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic    branch_rel_nz;
        logic    branch_rel_z;
        logic    branch_abs;
        logic    reg_write_en;
        logic    reg_sel;
        logic    lut_in;
        logic    mem_to_reg;
        logic    alu_src;
        logic    alu_sc_in;
        logic    read_mem;
        logic    write_mem;
        alu_op_t alu_op;
    } ctrl_bus_t;

endpackage

// File: rtl/proc_ctrl_instr_decode.sv
// Instruction decoder: opcode/fcode -> datapath control bus.
// Latency: purely combinational, same cycle.
// Backpressure: none; output follows input every cycle.
// Ports: opcode (instr[8:5]), fcode (instr[0]) in; ctrl (ctrl_bus_t) out.
module proc_ctrl_instr_decode
    import proc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       fcode,
    output ctrl_bus_t  ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (opcode_t'(opcode))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                ctrl.reg_write_en = 1'b1;
                // Opcodes 0..4 share their encoding with the ALU op.
                ctrl.alu_op       = alu_op_t'(opcode[2:0]);
            end
            OP_SHL, OP_SHR: begin
                // alu_op stays at its ADD default; fcode feeds the shift carry-in.
                ctrl.reg_write_en = 1'b1;
                ctrl.alu_sc_in    = fcode;
            end
            OP_ADDI: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.alu_op       = ALU_ADD;
            end
            OP_LD: begin
                ctrl.read_mem     = 1'b1;
                ctrl.mem_to_reg   = 1'b1;
                ctrl.reg_write_en = 1'b1;
            end
            OP_ST: begin
                ctrl.write_mem = 1'b1;
            end
            OP_BZ: begin
                ctrl.branch_rel_z = 1'b1;
                ctrl.alu_op       = ALU_PASS;
            end
            OP_BNZ: begin
                ctrl.branch_rel_nz = 1'b1;
                ctrl.alu_op        = ALU_PASS;
            end
            OP_JMP: begin
                ctrl.branch_abs = 1'b1;
            end
            OP_JMPR: begin
                ctrl.branch_abs = 1'b1;
                ctrl.lut_in     = 1'b1;
            end
            OP_LDPC: begin
                ctrl.reg_sel      = 1'b1;
                ctrl.reg_write_en = 1'b1;
            end
            OP_HALT: begin
                // Everything stays 0 so the final cycle cannot disturb state.
            end
        endcase
    end

endmodule

// File: rtl/proc_ctrl.sv
// Processor sequencer: run handshake (start_req -> INIT -> RUN -> FIN/done), decode gating,
// watchdog and cycle counter. Latency: CTRL_* combinational in RUN; done/timeout one cycle after exit.
// Backpressure: none; start_req at any time (re)starts the run, RUN aborts on start_req.
// Ports: CLK, reset (async active-high), start_req, dp_done, opcode[3:0], fcode in;
//        dp_start, CTRL_* , done, timeout, cycle_count, perf_mem_cnt, perf_br_cnt out.
// Build option: define PROC_CTRL_PERF_EN to enable the LD/ST and branch perf counters
//        (otherwise both perf ports are tied to 0).
module proc_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 60000
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start_req,
    input  logic             dp_done,
    input  logic [3:0]       opcode,
    input  logic             fcode,
    output logic             dp_start,
    output logic             CTRL_branch_rel_nz,
    output logic             CTRL_branch_rel_z,
    output logic             CTRL_branch_abs,
    output logic             CTRL_reg_write_en,
    output logic             CTRL_reg_sel,
    output logic             CTRL_lut_in,
    output logic             CTRL_mem_to_reg,
    output logic             CTRL_alu_src,
    output logic             CTRL_alu_sc_in,
    output logic             CTRL_read_mem,
    output logic             CTRL_write_mem,
    output logic [2:0]       CTRL_alu_op,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] perf_mem_cnt,
    output logic [CNT_W-1:0] perf_br_cnt
);

    localparam int               INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(MAX_CYCLES - 1);

    ctrl_state_t       state;
    logic [INIT_W-1:0] init_cnt;
    ctrl_bus_t         dec;
    ctrl_bus_t         ctrl;
    logic              go_init;
    logic              halt_op;
    logic              wd_hit;

    proc_ctrl_instr_decode instr_decode (
        .opcode (opcode),
        .fcode  (fcode),
        .ctrl   (dec)
    );

    // start_req from any state but INIT (re)enters INIT; in RUN this is an abort.
    assign go_init = start_req && (state != ST_INIT);
    assign halt_op = (opcode_t'(opcode) == OP_HALT);
    assign wd_hit  = (cycle_count == WD_LAST);

    // Decode only reaches the datapath in RUN, and never on an abort cycle.
    assign ctrl = ((state == ST_RUN) && !start_req) ? dec : '0;

    assign CTRL_branch_rel_nz = ctrl.branch_rel_nz;
    assign CTRL_branch_rel_z  = ctrl.branch_rel_z;
    assign CTRL_branch_abs    = ctrl.branch_abs;
    assign CTRL_reg_write_en  = ctrl.reg_write_en;
    assign CTRL_reg_sel       = ctrl.reg_sel;
    assign CTRL_lut_in        = ctrl.lut_in;
    assign CTRL_mem_to_reg    = ctrl.mem_to_reg;
    assign CTRL_alu_src       = ctrl.alu_src;
    assign CTRL_alu_sc_in     = ctrl.alu_sc_in;
    assign CTRL_read_mem      = ctrl.read_mem;
    assign CTRL_write_mem     = ctrl.write_mem;
    assign CTRL_alu_op        = ctrl.alu_op;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            init_cnt    <= '0;
            dp_start    <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else if (go_init) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            dp_start    <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt != INIT_LAST) begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                    if (!start_req && (init_cnt >= INIT_LAST)) begin
                        state    <= ST_RUN;
                        dp_start <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    if (halt_op || dp_done || wd_hit) begin
                        state   <= ST_FIN;
                        done    <= 1'b1;
                        // A HALT landing on the watchdog cycle is a clean finish.
                        timeout <= wd_hit && !halt_op;
                    end
                end
                default: begin
                    // IDLE and FIN hold until start_req (handled above).
                end
            endcase
        end
    end

`ifdef PROC_CTRL_PERF_EN
    logic [CNT_W-1:0] mem_cnt;
    logic [CNT_W-1:0] br_cnt;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_cnt <= '0;
            br_cnt  <= '0;
        end else if (go_init) begin
            mem_cnt <= '0;
            br_cnt  <= '0;
        end else if (state == ST_RUN) begin
            if ((ctrl.read_mem || ctrl.write_mem) && (mem_cnt != '1)) begin
                mem_cnt <= mem_cnt + CNT_W'(1);
            end
            if ((ctrl.branch_rel_z || ctrl.branch_rel_nz || ctrl.branch_abs) && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_mem_cnt = mem_cnt;
    assign perf_br_cnt  = br_cnt;
`else
    assign perf_mem_cnt = '0;
    assign perf_br_cnt  = '0;
`endif

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl with a watchdog limit of 100 cycles.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1-2 units later.
// Expected control words, run lengths and counters come from a table-driven reference model.
module tb_proc_ctrl;

    localparam int MAXC  = 100;
    localparam int INITC = 2;
    localparam int CW    = 16;
`ifdef PROC_CTRL_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic          CLK = 1'b0;
    logic          reset;
    logic          start_req;
    logic          dp_done;
    logic [3:0]    opcode;
    logic          fcode;
    logic          dp_start;
    logic          CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en;
    logic          CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in;
    logic          CTRL_read_mem, CTRL_write_mem;
    logic [2:0]    CTRL_alu_op;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] perf_mem_cnt;
    logic [CW-1:0] perf_br_cnt;
    logic [13:0]   obs_ctrl;

    proc_ctrl #(.INIT_CYCLES(INITC), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
        .CLK(CLK), .reset(reset), .start_req(start_req), .dp_done(dp_done),
        .opcode(opcode), .fcode(fcode), .dp_start(dp_start),
        .CTRL_branch_rel_nz(CTRL_branch_rel_nz), .CTRL_branch_rel_z(CTRL_branch_rel_z),
        .CTRL_branch_abs(CTRL_branch_abs), .CTRL_reg_write_en(CTRL_reg_write_en),
        .CTRL_reg_sel(CTRL_reg_sel), .CTRL_lut_in(CTRL_lut_in),
        .CTRL_mem_to_reg(CTRL_mem_to_reg), .CTRL_alu_src(CTRL_alu_src),
        .CTRL_alu_sc_in(CTRL_alu_sc_in), .CTRL_read_mem(CTRL_read_mem),
        .CTRL_write_mem(CTRL_write_mem), .CTRL_alu_op(CTRL_alu_op),
        .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .perf_mem_cnt(perf_mem_cnt), .perf_br_cnt(perf_br_cnt)
    );

    always #5 CLK = ~CLK;

    assign obs_ctrl = {CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
                       CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
                       CTRL_read_mem, CTRL_write_mem, CTRL_alu_op};

    int   checks = 0;
    int   errors = 0;
    int   exp_cycles;
    int   exp_mem;
    int   exp_br;
    logic exp_timeout;
    int   pq[$];
    bit   pf[$];

    // Reference decode table, same bit order as obs_ctrl.
    function automatic logic [13:0] model_ctrl(input int op, input logic f);
        logic [2:0] aop;
        if (op <= 4)                    aop = 3'(op);
        else if (op == 10 || op == 11)  aop = 3'd7;
        else                            aop = 3'd0;
        return {op == 11, op == 10, (op == 12 || op == 13), (op <= 8 || op == 14),
                op == 14, op == 13, op == 8, op == 7, ((op == 5 || op == 6) && f),
                op == 8, op == 9, aop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic add_op(input int op, input bit f);
        pq.push_back(op);
        pf.push_back(f);
    endtask

    task automatic clear_prog();
        pq.delete();
        pf.delete();
    endtask

    // Holds start_req for n cycles and follows the DUT through INIT into RUN.
    task automatic start_run(input int n);
        int hold;
        hold      = (n > INITC) ? n : INITC;
        opcode    = 4'($urandom_range(0, 14));
        fcode     = 1'($urandom_range(0, 1));
        start_req = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            chk("init_dp_start", dp_start, 1);
            chk("init_ctrl_zero", obs_ctrl, 0);
            if (i == 1) begin
                chk("init_done_clr", done, 0);
                chk("init_timeout_clr", timeout, 0);
                chk("init_cycles_clr", cycle_count, 0);
                chk("init_perf_mem_clr", perf_mem_cnt, 0);
                chk("init_perf_br_clr", perf_br_cnt, 0);
            end
            if (i == n) start_req = 1'b0;
        end
        tick();
        chk("run_dp_start_low", dp_start, 0);
        chk("run_first_ctrl", obs_ctrl, model_ctrl(int'(opcode), fcode));
        exp_cycles  = 0;
        exp_mem     = 0;
        exp_br      = 0;
        exp_timeout = 1'b0;
    endtask

    // Plays the queued program in RUN; dpd_end raises dp_done on the last entry.
    task automatic run_prog(input bit dpd_end);
        bit ended;
        ended = 1'b0;
        for (int i = 0; i < pq.size(); i++) begin
            opcode  = 4'(pq[i]);
            fcode   = pf[i];
            dp_done = dpd_end && (i == pq.size() - 1);
            #1;
            chk("run_ctrl", obs_ctrl, model_ctrl(pq[i], pf[i]));
            exp_cycles++;
            if (pq[i] == 8 || pq[i] == 9) exp_mem++;
            if (pq[i] >= 10 && pq[i] <= 13) exp_br++;
            ended       = (pq[i] == 15) || dp_done || (exp_cycles == MAXC);
            exp_timeout = (exp_cycles == MAXC) && (pq[i] != 15);
            tick();
            if (ended) break;
            chk("run_done_low", done, 0);
        end
        dp_done = 1'b0;
        chk("fin_done", done, 1);
        chk("fin_timeout", timeout, exp_timeout);
        chk("fin_cycles", cycle_count, exp_cycles);
        chk("fin_perf_mem", perf_mem_cnt, exp_mem * PERF_ON);
        chk("fin_perf_br", perf_br_cnt, exp_br * PERF_ON);
        opcode = 4'($urandom_range(0, 14));
        fcode  = 1'($urandom_range(0, 1));
        #1;
        chk("fin_ctrl_zero", obs_ctrl, 0);
        tick();
        chk("fin_done_held", done, 1);
        chk("fin_cycles_held", cycle_count, exp_cycles);
    endtask

    task automatic rand_prog(input int len, input bit use_dpd);
        clear_prog();
        for (int i = 0; i < len - 1; i++) add_op($urandom_range(0, 14), 1'($urandom_range(0, 1)));
        add_op(use_dpd ? $urandom_range(0, 14) : 15, 1'($urandom_range(0, 1)));
    endtask

    task automatic perf_prog();
        int a[9] = '{8, 8, 8, 9, 9, 11, 11, 11, 11};
        int tmp;
        int j;
        for (int i = 8; i > 0; i--) begin
            j    = $urandom_range(0, i);
            tmp  = a[i];
            a[i] = a[j];
            a[j] = tmp;
        end
        clear_prog();
        for (int i = 0; i < 9; i++) add_op(a[i], 1'($urandom_range(0, 1)));
        add_op(15, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        start_req = 1'b0;
        dp_done   = 1'b0;
        opcode    = 4'd0;
        fcode     = 1'b0;
        tick();
        tick();
        chk("rst_ctrl", obs_ctrl, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_perf_mem", perf_mem_cnt, 0);
        chk("rst_perf_br", perf_br_cnt, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("idle_ctrl_zero", obs_ctrl, 0);
        chk("idle_dp_start", dp_start, 0);

        // Five-cycle start pulse, then full opcode/fcode sweep ending in HALT.
        start_run(5);
        clear_prog();
        for (int op = 0; op < 15; op++) begin
            add_op(op, 1'b0);
            add_op(op, 1'b1);
        end
        add_op(15, 1'b0);
        run_prog(1'b0);

        // Twenty ADDs then HALT.
        start_run($urandom_range(1, 4));
        clear_prog();
        for (int i = 0; i < 20; i++) add_op(0, 1'($urandom_range(0, 1)));
        add_op(15, 1'b0);
        run_prog(1'b0);

        // Random programs ending in HALT or in dp_done.
        for (int k = 0; k < 6; k++) begin
            start_run($urandom_range(1, 4));
            rand_prog($urandom_range(3, 60), 1'(k % 2));
            run_prog(1'(k % 2));
        end

        // Watchdog expiry, then HALT landing on the watchdog cycle.
        start_run(2);
        clear_prog();
        for (int i = 0; i < MAXC; i++) add_op($urandom_range(0, 14), 1'($urandom_range(0, 1)));
        run_prog(1'b0);
        start_run(1);
        clear_prog();
        for (int i = 0; i < MAXC - 1; i++) add_op($urandom_range(0, 14), 1'($urandom_range(0, 1)));
        add_op(15, 1'b0);
        run_prog(1'b0);

        // Perf counters: 3 LD, 2 ST, 4 BNZ in random order, then HALT.
        start_run(3);
        perf_prog();
        run_prog(1'b0);

        // Abort from RUN after a few instructions; restart must clear the old run.
        start_run(2);
        for (int i = 0; i < 5; i++) begin
            opcode = 4'($urandom_range(0, 14));
            tick();
        end
        opcode    = 4'd8;
        start_req = 1'b1;
        #1;
        chk("abort_ctrl_zero", obs_ctrl, 0);
        start_run(3);
        rand_prog(8, 1'b0);
        run_prog(1'b0);

        // Asynchronous reset in the 10th RUN cycle.
        start_run(2);
        for (int i = 0; i < 9; i++) begin
            opcode = 4'($urandom_range(0, 14));
            tick();
        end
        opcode = 4'd8;
        fcode  = 1'b0;
        #1;
        chk("pre_rst_ctrl", obs_ctrl, model_ctrl(8, 1'b0));
        chk("pre_rst_cycles", cycle_count, 9);
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", obs_ctrl, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cycles", cycle_count, 0);
        chk("midrst_dp_start", dp_start, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_idle_ctrl", obs_ctrl, 0);
        chk("post_rst_idle_dp_start", dp_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
